// File: rtl/conv_tile_scheduler_if.sv
// Engine-side bundle of the conv tile scheduler: per-job addresses/config and the
// op_start/end_conv handshake plus OFM write-buffer drain status.
interface conv_tile_scheduler_if #(
    parameter int ADDR_W = 64
);
    logic              op_start;
    logic [ADDR_W-1:0] ifm_addr_base;
    logic [ADDR_W-1:0] wgt_addr_base;
    logic [ADDR_W-1:0] ofm_addr_base;
    logic [1:0]        eng_cfg_ci;
    logic [1:0]        eng_cfg_co;
    logic              end_conv;
    logic              write_buffer_wait;

    modport master (
        output op_start,
        output ifm_addr_base,
        output wgt_addr_base,
        output ofm_addr_base,
        output eng_cfg_ci,
        output eng_cfg_co,
        input  end_conv,
        input  write_buffer_wait
    );

    modport slave (
        input  op_start,
        input  ifm_addr_base,
        input  wgt_addr_base,
        input  ofm_addr_base,
        input  eng_cfg_ci,
        input  eng_cfg_co,
        output end_conv,
        output write_buffer_wait
    );
endinterface

// File: rtl/conv_tile_scheduler.sv
// Layer sequencer: tiles (outer) x output-channel groups (inner), one engine job each.
// op_start 2 cycles after ap_start; stalls on end_conv / write_buffer_wait. Watchdog: CONV_TILE_SCHED_WDOG_EN.
module conv_tile_scheduler #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 64,
    parameter int WDOG_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ap_start,
    input  logic [CNT_W-1:0]     cfg_num_tiles,
    input  logic [CNT_W-1:0]     cfg_num_cog,
    input  logic [ADDR_W-1:0]    cfg_ifm_base,
    input  logic [ADDR_W-1:0]    cfg_wgt_base,
    input  logic [ADDR_W-1:0]    cfg_ofm_base,
    input  logic [ADDR_W-1:0]    cfg_ifm_stride,
    input  logic [ADDR_W-1:0]    cfg_wgt_stride,
    input  logic [ADDR_W-1:0]    cfg_ofm_stride,
    input  logic [1:0]           cfg_ci,
    input  logic [1:0]           cfg_co,
    input  logic [WDOG_W-1:0]    cfg_wdog_limit,
    conv_tile_scheduler_if.master eng,
    output logic                 busy,
    output logic                 done,
    output logic                 wdog_err,
    output logic [2*CNT_W-1:0]   job_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DRAIN,
        S_NEXT,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  t_q, t_d;
    logic [CNT_W-1:0]  g_q, g_d;
    logic [CNT_W-1:0]  num_tiles_q, num_tiles_d;
    logic [CNT_W-1:0]  num_cog_q, num_cog_d;
    logic [ADDR_W-1:0] wgt_base_q, wgt_base_d;
    logic [ADDR_W-1:0] ifm_stride_q, ifm_stride_d;
    logic [ADDR_W-1:0] wgt_stride_q, wgt_stride_d;
    logic [ADDR_W-1:0] ofm_stride_q, ofm_stride_d;
    logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d;
    logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
    logic [ADDR_W-1:0] ofm_addr_q, ofm_addr_d;
    logic [1:0]        ci_q, ci_d;
    logic [1:0]        co_q, co_d;
    logic [CNT_W-1:0]  last_tile;
    logic [CNT_W-1:0]  last_cog;

`ifdef CONV_TILE_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic [WDOG_W-1:0] wdog_lim_q, wdog_lim_d;
    logic              wdog_err_q, wdog_err_d;
`else
    logic              unused_wdog_limit;
    assign unused_wdog_limit = ^cfg_wdog_limit;
`endif

    // Only meaningful once LOAD has ruled out zero counts.
    assign last_tile = num_tiles_q - CNT_W'(1);
    assign last_cog  = num_cog_q - CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        g_d          = g_q;
        num_tiles_d  = num_tiles_q;
        num_cog_d    = num_cog_q;
        wgt_base_d   = wgt_base_q;
        ifm_stride_d = ifm_stride_q;
        wgt_stride_d = wgt_stride_q;
        ofm_stride_d = ofm_stride_q;
        ifm_addr_d   = ifm_addr_q;
        wgt_addr_d   = wgt_addr_q;
        ofm_addr_d   = ofm_addr_q;
        ci_d         = ci_q;
        co_d         = co_q;
`ifdef CONV_TILE_SCHED_WDOG_EN
        wdog_cnt_d   = wdog_cnt_q;
        wdog_lim_d   = wdog_lim_q;
        wdog_err_d   = wdog_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d      = S_LOAD;
                    num_tiles_d  = cfg_num_tiles;
                    num_cog_d    = cfg_num_cog;
                    wgt_base_d   = cfg_wgt_base;
                    ifm_stride_d = cfg_ifm_stride;
                    wgt_stride_d = cfg_wgt_stride;
                    ofm_stride_d = cfg_ofm_stride;
                    ifm_addr_d   = cfg_ifm_base;
                    wgt_addr_d   = cfg_wgt_base;
                    ofm_addr_d   = cfg_ofm_base;
                    ci_d         = cfg_ci;
                    co_d         = cfg_co;
                    t_d          = '0;
                    g_d          = '0;
`ifdef CONV_TILE_SCHED_WDOG_EN
                    wdog_lim_d   = cfg_wdog_limit;
                    wdog_err_d   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (num_tiles_q == '0 || num_cog_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (eng.end_conv) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!eng.write_buffer_wait) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                ofm_addr_d = ofm_addr_q + ofm_stride_q;
                if (g_q != last_cog) begin
                    g_d        = g_q + CNT_W'(1);
                    wgt_addr_d = wgt_addr_q + wgt_stride_q;
                    state_d    = S_START;
                end else if (t_q != last_tile) begin
                    t_d        = t_q + CNT_W'(1);
                    g_d        = '0;
                    wgt_addr_d = wgt_base_q;
                    ifm_addr_d = ifm_addr_q + ifm_stride_q;
                    state_d    = S_START;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef CONV_TILE_SCHED_WDOG_EN
        // A hung job aborts the whole layer; done still pulses so the host is released.
        if (state_q == S_RUN || state_q == S_DRAIN) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            if (wdog_lim_q != '0 && wdog_cnt_d >= wdog_lim_q) begin
                wdog_err_d = 1'b1;
                state_d    = S_FIN;
            end
        end
        if (state_d == S_START) begin
            wdog_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            g_q          <= '0;
            num_tiles_q  <= '0;
            num_cog_q    <= '0;
            wgt_base_q   <= '0;
            ifm_stride_q <= '0;
            wgt_stride_q <= '0;
            ofm_stride_q <= '0;
            ifm_addr_q   <= '0;
            wgt_addr_q   <= '0;
            ofm_addr_q   <= '0;
            ci_q         <= '0;
            co_q         <= '0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            g_q          <= g_d;
            num_tiles_q  <= num_tiles_d;
            num_cog_q    <= num_cog_d;
            wgt_base_q   <= wgt_base_d;
            ifm_stride_q <= ifm_stride_d;
            wgt_stride_q <= wgt_stride_d;
            ofm_stride_q <= ofm_stride_d;
            ifm_addr_q   <= ifm_addr_d;
            wgt_addr_q   <= wgt_addr_d;
            ofm_addr_q   <= ofm_addr_d;
            ci_q         <= ci_d;
            co_q         <= co_d;
        end
    end

`ifdef CONV_TILE_SCHED_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_lim_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_lim_q <= wdog_lim_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_err = 1'b0;
`endif

    assign eng.op_start      = (state_q == S_START);
    assign eng.ifm_addr_base = ifm_addr_q;
    assign eng.wgt_addr_base = wgt_addr_q;
    assign eng.ofm_addr_base = ofm_addr_q;
    assign eng.eng_cfg_ci    = ci_q;
    assign eng.eng_cfg_co    = co_q;

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_FIN);
    assign job_idx = {t_q, g_q};

endmodule
